// File: rtl/timer_arbiter.sv
// ---------------------------------------------------------------------------
// TimerArbiter -- four requesters share one prescaler and one down-counter.
//
// A round-robin arbiter picks one requester while idle. That requester owns
// the timer until its programmed delay (in prescaled ticks) has elapsed, or
// until it withdraws its request.
//
// Parameters
//   CLK_FREQ  main clock frequency in Hz
//   TICK_HZ   timer tick rate in Hz; PRESC = CLK_FREQ / TICK_HZ, must be >= 2
//   DLY_W     width of each delay field, in ticks
//
// Ports
//   clk_In   in   1        sole clock, rising edge
//   rst_n    in   1        synchronous active-low reset
//   req      in   4        level request per requester, held until done/abort
//   req_dly  in   4*DLY_W  delay for requester i in [i*DLY_W +: DLY_W],
//                          captured only at grant
//   gnt      out  4        one-hot grant, high for the whole timing run
//   done     out  4        one-cycle completion pulse for the served requester
//   busy     out  1        high while running or signalling completion
//   cur_id   out  2        index of the current or last granted requester
// ---------------------------------------------------------------------------
module timer_arbiter #(
   parameter int CLK_FREQ = 12090000,
   parameter int TICK_HZ  = 250000,
   parameter int DLY_W    = 16
) (
   input  logic               clk_In,
   input  logic               rst_n,
   input  logic [3:0]         req,
   input  logic [4*DLY_W-1:0] req_dly,
   output logic [3:0]         gnt,
   output logic [3:0]         done,
   output logic               busy,
   output logic [1:0]         cur_id
);

   localparam int PRESC   = CLK_FREQ / TICK_HZ;
   localparam int PRESC_W = (PRESC > 2) ? $clog2(PRESC) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } stateType;

   stateType           state, stateNext;
   logic [1:0]         curId, curIdNext;
   logic [1:0]         ptr, ptrNext;
   logic [DLY_W-1:0]   count, countNext;
   logic [PRESC_W-1:0] presc, prescNext;

   logic               winnerFound;
   logic [1:0]         winner;
   logic [1:0]         searchIdx;
   logic               tick;

   // The prescaler wraps at PRESC-1. Reaching that value is one timer tick,
   // so the counter steps down once every PRESC cycles while running.
   assign tick = (presc == PRESC_LAST);

   // Round-robin search: scan upward from ptr and wrap 3->0. The first
   // active request found wins. ptr moves past a requester only once it
   // completes, so a requester that keeps its request asserted after done
   // has to wait for every other active requester.
   always_comb begin
      winnerFound = 1'b0;
      winner      = ptr;
      searchIdx   = 2'd0;
      for (int i = 0; i < 4; i++) begin
         searchIdx = ptr + 2'(i);
         if (!winnerFound && req[searchIdx]) begin
            winnerFound = 1'b1;
            winner      = searchIdx;
         end
      end
   end

   // All state lives here. Reset is synchronous and outranks every other
   // transition. A reset in the middle of a run therefore drops the grant
   // silently, with no completion pulse.
   always_ff @(posedge clk_In) begin
      if (!rst_n) begin
         state <= IDLE;
         curId <= 2'd0;
         ptr   <= 2'd0;
         count <= '0;
         presc <= '0;
      end else begin
         state <= stateNext;
         curId <= curIdNext;
         ptr   <= ptrNext;
         count <= countNext;
         presc <= prescNext;
      end
   end

   // Next-state logic. The delay is captured only at grant, so later changes
   // to req_dly have no effect on a run in progress. In RUN the checks are
   // applied in order: an abort outranks expiry, and expiry outranks a tick.
   // Once the count is zero it is never decremented again. The prescaler is
   // held at zero outside active counting, so every run starts a full tick
   // period from the grant.
   always_comb begin
      stateNext = state;
      curIdNext = curId;
      ptrNext   = ptr;
      countNext = count;
      prescNext = '0;
      case (state)
         IDLE: begin
            if (winnerFound) begin
               stateNext = RUN;
               curIdNext = winner;
               countNext = req_dly[winner*DLY_W +: DLY_W];
            end
         end
         RUN: begin
            if (!req[curId]) begin
               stateNext = IDLE;
            end else if (count == '0) begin
               stateNext = DONE;
               ptrNext   = curId + 2'd1;
            end else begin
               if (tick) begin
                  countNext = count - 1'b1;
                  prescNext = '0;
               end else begin
                  prescNext = presc + 1'b1;
               end
            end
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Outputs are decoded from registered state only, so they are glitch
   // free. The done pulse uses the same owner index as the grant before it.
   // That makes done equal to the grant of the previous cycle.
   always_comb begin
      gnt    = '0;
      done   = '0;
      busy   = 1'b0;
      cur_id = curId;
      if (state == RUN) begin
         gnt  = 4'b0001 << curId;
         busy = 1'b1;
      end else if (state == DONE) begin
         done = 4'b0001 << curId;
         busy = 1'b1;
      end
   end

endmodule
